// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and constants for the register bank arbiter
package regbank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic HOST_I2C = 1'b0;
    localparam logic HOST_SPI = 1'b1;

endpackage

// File: rtl/txn_timer.sv
// rtl/txn_timer.sv - loadable up-counter that flags the last allowed ISSUE cycle
module txn_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of completed ISSUE cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = en && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - round-robin arbiter sharing one register bank between two hosts
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h0_req,
    input  logic              h0_we,
    input  logic [ADDR_W-1:0] h0_addr,
    input  logic [DATA_W-1:0] h0_wdata,
    output logic              h0_ack,
    output logic [DATA_W-1:0] h0_rdata,
    output logic              h0_err,
    input  logic              h1_req,
    input  logic              h1_we,
    input  logic [ADDR_W-1:0] h1_addr,
    input  logic [DATA_W-1:0] h1_wdata,
    output logic              h1_ack,
    output logic [DATA_W-1:0] h1_rdata,
    output logic              h1_err,
    output logic              t_req,
    output logic              t_we,
    output logic [ADDR_W-1:0] t_addr,
    output logic [DATA_W-1:0] t_wdata,
    input  logic              t_ack,
    input  logic [DATA_W-1:0] t_rdata,
    output logic              busy,
    output logic              last_grant,
    output logic [7:0]        timeout_cnt
);

    state_t            state;
    state_t            state_next;
    logic              pick;
    logic              grant;
    logic              expire;
    logic              grant_now;
    logic              finish;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;

    txn_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == IDLE),
        .en     (state == ISSUE),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On a tie the host that did not win last time goes first
    always_comb begin
        state_next = state;
        pick       = HOST_I2C;
        case (state)
            IDLE: begin
                if (h0_req && h1_req) begin
                    pick       = ~last_grant;
                    state_next = ISSUE;
                end else if (h0_req) begin
                    pick       = HOST_I2C;
                    state_next = ISSUE;
                end else if (h1_req) begin
                    pick       = HOST_SPI;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (t_ack || expire) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_now = (state == IDLE) && (state_next == ISSUE);
    assign finish    = (state == ISSUE) && (state_next == RESP);
    assign resp_err  = !t_ack;
    assign resp_data = (t_ack && !t_we) ? t_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= HOST_I2C;
            last_grant  <= HOST_SPI;
            t_req       <= 1'b0;
            t_we        <= 1'b0;
            t_addr      <= '0;
            t_wdata     <= '0;
            h0_ack      <= 1'b0;
            h0_rdata    <= '0;
            h0_err      <= 1'b0;
            h1_ack      <= 1'b0;
            h1_rdata    <= '0;
            h1_err      <= 1'b0;
            busy        <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            busy   <= (state_next != IDLE);
            t_req  <= (state_next == ISSUE);
            h0_ack <= 1'b0;
            h1_ack <= 1'b0;
            if (grant_now) begin
                grant      <= pick;
                last_grant <= pick;
                t_we       <= pick ? h1_we    : h0_we;
                t_addr     <= pick ? h1_addr  : h0_addr;
                t_wdata    <= pick ? h1_wdata : h0_wdata;
            end
            if (finish) begin
                if (grant == HOST_I2C) begin
                    h0_ack   <= 1'b1;
                    h0_rdata <= resp_data;
                    h0_err   <= resp_err;
                end else begin
                    h1_ack   <= 1'b1;
                    h1_rdata <= resp_data;
                    h1_err   <= resp_err;
                end
                if (resp_err && (timeout_cnt != 8'hFF)) begin
                    timeout_cnt <= timeout_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-host arbiter that shares the single-ported application register bank between the I2C peripheral's application bus and the SPI peripheral's application bus. It latches one host transaction at a time, drives the bank through a req/ack handshake, returns read data with a one-cycle ack pulse, and aborts bank accesses that stall beyond a timeout. Round-robin grant keeps either serial interface from starving the other.

## Interface
- ADDR_W, 8, register address width
- DATA_W, 8, register data width
- TIMEOUT, 15, cycles allowed in ISSUE before abort; 0 disables the timeout
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- h0_req, h1_req  input  1  host request level; held until ack
- h0_we, h1_we  input  1  1 = write, 0 = read
- h0_addr, h1_addr  input  ADDR_W  register address
- h0_wdata, h1_wdata  input  DATA_W  write data
- h0_ack, h1_ack  output  1  one-cycle completion pulse
- h0_rdata, h1_rdata  output  DATA_W  read data; valid with ack, held until next ack to that host
- h0_err, h1_err  output  1  valid with ack; 1 = timed out
- t_req  output  1  bank request
- t_we, t_addr, t_wdata  output  1/ADDR_W/DATA_W  latched transaction fields
- t_ack  input  1  bank completion; t_rdata sampled in the same cycle
- t_rdata  input  DATA_W  bank read data
- busy  output  1  FSM not in IDLE
- last_grant  output  1  index of most recently granted host
- timeout_cnt  output  8  saturating count of aborted transactions

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if only one req is high, grant that host. If both are high, grant the host != last_grant. Latch we/addr/wdata and the grant index, set last_grant, clear the timer, go to ISSUE.
- ISSUE: t_req=1 with latched fields; timer increments each cycle.
  - t_ack=1: capture t_rdata (writes capture 0); go to RESP with err=0.
  - TIMEOUT≠0 and timer reaches TIMEOUT with no t_ack: drop t_req; go to RESP with err=1 and rdata=0; timeout_cnt +1, saturating at 255.
  - t_ack wins if it arrives in the same cycle as expiry.
- RESP: pulse ack for the granted host only, with rdata/err; go to IDLE.
- Host fields are latched at grant. Changing or dropping req during ISSUE/RESP has no effect; the transaction completes and ack still pulses.
- Reset values:
  - state=IDLE, last_grant=1 (so host 0 wins the first tie).
  - All ack/err/t_req/t_we=0; t_addr, t_wdata, rdata=0; timeout_cnt=0; busy=0.
- Reset mid-transaction: t_req and ack are low the cycle after reset is sampled. The in-flight transaction is dropped with no ack and no count.

## Timing
- req sampled in IDLE at edge k. t_req is high from cycle k+1.
- t_ack in cycle m: hN_ack is high in cycle m+1 only.
- Minimum request-to-ack: 2 cycles (t_ack in the first ISSUE cycle). Minimum cycle for back-to-back transactions: 3 cycles (IDLE, ISSUE, RESP).
- A host must have req low in the cycle after its ack; registered deassertion on seeing ack satisfies this. A req still high in IDLE is a new transaction.
- Timeout abort: ack arrives TIMEOUT+1 cycles after t_req rises.
- t_req never stays high across RESP/IDLE; there is at least one low cycle between bank requests.
- Outputs are registered; there are no combinational paths from host inputs to bank outputs.

## Structure
- Package regbank_pkg:
  - state enum {IDLE, ISSUE, RESP}
  - default ADDR_W/DATA_W constants
  - host index constants HOST_I2C=0, HOST_SPI=1
- Arbitration and FSM stay inline.
- One natural sub-module, txn_timer: a loadable up-counter with an expire flag, parameterised by TIMEOUT, with a disable when TIMEOUT=0.

## Test plan
- Single read: h0 read addr 0x12, bank acks after 3 cycles with 0xA5 -> h0_ack pulses once, h0_rdata=0xA5, h0_err=0, h1_ack never pulses.
- Simultaneous req after reset: h0 write 0x01←0x11, h1 write 0x02←0x22 -> h0 served first, then h1. Bank sees addr 0x01 then 0x02; last_grant ends at 1.
- Fairness: both hosts hold continuous back-to-back reqs for 10 transactions -> grants strictly alternate 0,1,0,1…; each completes in 3 cycles with zero-wait t_ack.
- Timeout: TIMEOUT=15, t_ack held low -> t_req drops after 15 ISSUE cycles; h1_ack with err=1 and rdata=0 at cycle 16 after t_req rise; timeout_cnt=1. Repeat 256 times -> count holds at 255.
- Field stability: h0 changes addr and drops req during ISSUE -> bank still sees the original addr; h0_ack still pulses.
- Reset mid-ISSUE: assert rst with t_req high -> next cycle t_req=0, busy=0, no ack. After release, h1 request is served normally.
